// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for serial_universal_comparator
package cmp_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_GT   = 3'b100,
        RES_EQ   = 3'b010,
        RES_LT   = 3'b001
    } result_t;
    function automatic int slice_count(input int width, input int digit);
        return width / digit;
    endfunction
endpackage

// File: rtl/slice_compare.sv
// slice_compare: DIGIT-bit unsigned magnitude compare of one operand slice
module slice_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    output logic             o_gt,
    output logic             o_lt
);
    assign o_gt = i_a > i_b;
    assign o_lt = i_a < i_b;
endmodule

// File: rtl/serial_universal_comparator.sv
// serial_universal_comparator: MSB-first slice-serial signed/unsigned compare with valid/ready.
// Define CMP_EARLY_EXIT_EN to stop scanning at the first differing slice.
module serial_universal_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int DIGIT = 2,
    localparam int N     = slice_count(WIDTH, DIGIT),
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             greater,
    output logic             equal,
    output logic             smaller,
    output logic [CW-1:0]    cycles
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    result_t          r_res;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] w_sa [N];
    logic [DIGIT-1:0] w_sb [N];
    logic             w_gt;
    logic             w_lt;
    logic             w_last;

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign w_sa[g] = r_a[g*DIGIT +: DIGIT];
        assign w_sb[g] = r_b[g*DIGIT +: DIGIT];
    end

    slice_compare #(.DIGIT(DIGIT)) u_slice (
        .i_a  (w_sa[r_idx]),
        .i_b  (w_sb[r_idx]),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    assign w_last    = r_idx == '0;
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign {greater, equal, smaller} = out_valid ? r_res : RES_NONE;
    assign cycles    = out_valid ? r_cnt : '0;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
            r_res   <= RES_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    // flipping both sign bits maps two's-complement order onto unsigned order
                    r_a     <= {A[WIDTH-1] ^ signed_flag, A[WIDTH-2:0]};
                    r_b     <= {B[WIDTH-1] ^ signed_flag, B[WIDTH-2:0]};
                    r_idx   <= IW'(N - 1);
                    r_cnt   <= '0;
                    r_res   <= RES_EQ;
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
`ifdef CMP_EARLY_EXIT_EN
                    if (w_gt || w_lt)
                        r_res <= w_gt ? RES_GT : RES_LT;
                    if (w_gt || w_lt || w_last)
                        r_state <= DONE;
                    else
                        r_idx <= r_idx - IW'(1);
`else
                    if ((w_gt || w_lt) && r_res == RES_EQ)
                        r_res <= w_gt ? RES_GT : RES_LT;
                    if (w_last)
                        r_state <= DONE;
                    else
                        r_idx <= r_idx - IW'(1);
`endif
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_universal_comparator.sv
// tb_serial_universal_comparator: directed and random checks of 6/2 and 8/1 comparators
// against an arithmetic reference; follows CMP_EARLY_EXIT_EN like the RTL build.
module tb_serial_universal_comparator;
    logic       CLK = 0;
    logic       CLR = 0;
    logic       in_valid = 0;
    logic       signed_flag = 0;
    logic       out_ready = 0;
    logic       sel8 = 0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       ir6, ov6, g6, e6, s6;
    logic       ir8, ov8, g8, e8, s8;
    logic [1:0] cy6;
    logic [3:0] cy8;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 CLK = ~CLK;

    serial_universal_comparator #(.WIDTH(6), .DIGIT(2)) u6 (
        .CLK(CLK), .CLR(CLR), .in_valid(in_valid & ~sel8), .in_ready(ir6),
        .A(A[5:0]), .B(B[5:0]), .signed_flag(signed_flag),
        .out_valid(ov6), .out_ready(out_ready),
        .greater(g6), .equal(e6), .smaller(s6), .cycles(cy6)
    );

    serial_universal_comparator #(.WIDTH(8), .DIGIT(1)) u8 (
        .CLK(CLK), .CLR(CLR), .in_valid(in_valid & sel8), .in_ready(ir8),
        .A(A), .B(B), .signed_flag(signed_flag),
        .out_valid(ov8), .out_ready(out_ready),
        .greater(g8), .equal(e8), .smaller(s8), .cycles(cy8)
    );

    wire       ir  = sel8 ? ir8 : ir6;
    wire       ov  = sel8 ? ov8 : ov6;
    wire [2:0] res = sel8 ? {g8, e8, s8} : {g6, e6, s6};
    wire [3:0] cy  = sel8 ? cy8 : {2'b00, cy6};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: numeric compare of the operands; k = first differing slice from the MSB
    function automatic void model(input int w, input int d, input logic [7:0] a, input logic [7:0] b,
                                  input bit s, output logic [2:0] r, output int k);
        int va, vb, n, x;
        va = int'(a) & ((1 << w) - 1);
        vb = int'(b) & ((1 << w) - 1);
        x  = va ^ vb;
        if (s && va >= (1 << (w - 1))) va -= (1 << w);
        if (s && vb >= (1 << (w - 1))) vb -= (1 << w);
        r = va > vb ? 3'b100 : (va == vb ? 3'b010 : 3'b001);
        n = w / d;
        k = n;
`ifdef CMP_EARLY_EXIT_EN
        for (int i = n - 1; i >= 0; i--)
            if (k == n && ((x >> (i * d)) & ((1 << d) - 1)) != 0) k = n - i;
`else
        if (x < 0) k = 0;
`endif
    endfunction

    task automatic run(input logic [7:0] a, input logic [7:0] b, input bit s, input int hold);
        logic [2:0] er;
        int ek, n;
        model(sel8 ? 8 : 6, sel8 ? 1 : 2, a, b, s, er, ek);
        @(negedge CLK);
        check("idle_ready", ir, 1);
        A = a; B = b; signed_flag = s; in_valid = 1;
        @(negedge CLK);
        in_valid = 0; A = 8'($urandom); B = 8'($urandom); signed_flag = 1'($urandom);
        check("busy_ready", ir, 0);
        n = 0;
        while (!ov && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("latency", n, ek);
        check("result", res, er);
        check("cycles", cy, ek);
        check("done_ready", ir, 0);
        repeat (hold) begin
            A = 8'($urandom); B = 8'($urandom); in_valid = 1'($urandom);
            @(negedge CLK);
            check("hold_valid", ov, 1);
            check("hold_result", res, er);
            check("hold_cycles", cy, ek);
            check("hold_ready", ir, 0);
        end
        out_ready = 1; in_valid = 1;
        @(negedge CLK);
        check("release_valid", ov, 0);
        check("no_accept_on_release", ir, 1);
        check("release_result", res, 0);
        out_ready = 0; in_valid = 0;
    endtask

    initial begin
        #2;
        check("rst_ready6", ir6, 1);
        check("rst_ready8", ir8, 1);
        check("rst_out6", {ov6, g6, e6, s6, cy6}, 0);
        check("rst_out8", {ov8, g8, e8, s8, cy8}, 0);
        @(negedge CLK);
        CLR = 1;
        sel8 = 0;
        run(8'b110000, 8'b010000, 0, 0);
        run(8'b110000, 8'b010000, 1, 0);
        run(8'b111111, 8'b111110, 1, 0);
        run(8'b101101, 8'b101101, 0, 0);
        run(8'b101101, 8'b101101, 1, 0);
        run(8'b100000, 8'b000000, 0, 0);
        run(8'b000001, 8'b000010, 1, 5);
        @(negedge CLK);
        A = 8'b110000; B = 8'b110001; signed_flag = 0; in_valid = 1;
        @(negedge CLK);
        in_valid = 0;
        @(negedge CLK);
        check("mid_busy_ready", ir6, 0);
        CLR = 0;
        #1;
        check("clr_ready", ir6, 1);
        check("clr_out", {ov6, g6, e6, s6, cy6}, 0);
        #1;
        CLR = 1;
        run(8'b011010, 8'b011001, 1, 1);
        sel8 = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : (a ^ 8'($urandom_range(1, 255) >> $urandom_range(0, 7)));
            run(a, b, 1'(i & 1), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
